// File: rtl/cpu_pkg.sv
// Shared opcode, state and IR-field definitions for the Phase-1 control path.
// Pure constants; no logic, no latency, no flow control.
// Imported by the sequencer and the opcode decoder.
package cpu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_SHRA = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_T0   = 3'd1;
    localparam logic [2:0] ST_T1   = 3'd2;
    localparam logic [2:0] ST_T2   = 3'd3;
    localparam logic [2:0] ST_T3   = 3'd4;
    localparam logic [2:0] ST_T4   = 3'd5;
    localparam logic [2:0] ST_T5   = 3'd6;
    localparam logic [2:0] ST_HALT = 3'd7;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;

    // ALU select bit order, MSB first: ADD SUB AND OR SHR SHRA SHL ROR ROL
    localparam int ALU_SEL_W = 9;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode to one-hot ALU select plus legal flag.
// Latency: purely combinational.
// Backpressure: none.
module alu_op_decode
    import cpu_pkg::*;
(
    input  logic [4:0]           opcode,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 legal
);

    always_comb begin
        alu_sel = '0;
        legal   = 1'b1;
        case (opcode)
            OP_ADD:  alu_sel = 9'b1_0000_0000;
            OP_SUB:  alu_sel = 9'b0_1000_0000;
            OP_AND:  alu_sel = 9'b0_0100_0000;
            OP_OR:   alu_sel = 9'b0_0010_0000;
            OP_SHR:  alu_sel = 9'b0_0001_0000;
            OP_SHRA: alu_sel = 9'b0_0000_1000;
            OP_SHL:  alu_sel = 9'b0_0000_0100;
            OP_ROR:  alu_sel = 9'b0_0000_0010;
            OP_ROL:  alu_sel = 9'b0_0000_0001;
            default: legal   = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired T0-T5 sequencer for three-register ALU instructions on the Phase-1 datapath.
// Latency: run high in IDLE gives T0 strobes next cycle; six cycles per instruction.
// Backpressure: none; run is sampled only in IDLE and T5, HALT waits for clear.
module alu_control_sequencer
    import cpu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic [31:0]      IR,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             ADD,
    output logic             SUB,
    output logic             AND,
    output logic             OR,
    output logic             SHR,
    output logic             SHRA,
    output logic             SHL,
    output logic             ROR,
    output logic             ROL,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [ALU_SEL_W-1:0] alu_sel;
    logic                 op_legal;
    logic [3:0]           ra_idx;
    logic [3:0]           rb_idx;
    logic [3:0]           rc_idx;
    logic                 unused_ir;

    assign ra_idx    = IR[IR_RA_MSB:IR_RA_LSB];
    assign rb_idx    = IR[IR_RB_MSB:IR_RB_LSB];
    assign rc_idx    = IR[IR_RC_MSB:IR_RC_LSB];
    assign unused_ir = ^IR[IR_RC_LSB-1:0];

    alu_op_decode u_alu_op_decode (
        .opcode  (IR[IR_OP_MSB:IR_OP_LSB]),
        .alu_sel (alu_sel),
        .legal   (op_legal)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (run) state_nxt = ST_T0;
            ST_T0:   state_nxt = ST_T1;
            ST_T1:   state_nxt = ST_T2;
            ST_T2:   state_nxt = ST_T3;
            ST_T3:   state_nxt = op_legal ? ST_T4 : ST_HALT;
            ST_T4:   state_nxt = ST_T5;
            ST_T5:   state_nxt = run ? ST_T0 : ST_IDLE;
            default: state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= ST_IDLE;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_T5)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    // IR fields are only looked at in T3-T5, once the fetched word has landed in IR
    always_comb begin
        {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout} = '0;
        {ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL} = '0;
        Rin  = '0;
        Rout = '0;
        case (state)
            ST_T0: {PCout, MARin, IncPC, Zin} = 4'b1111;
            ST_T1: {Zlowout, PCin, Read, MDRin} = 4'b1111;
            ST_T2: {MDRout, IRin} = 2'b11;
            ST_T3: begin
                Rout[rb_idx] = 1'b1;
                Yin          = 1'b1;
            end
            ST_T4: begin
                Rout[rc_idx] = 1'b1;
                Zin          = 1'b1;
                {ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL} = alu_sel;
            end
            ST_T5: begin
                Zlowout      = 1'b1;
                Rin[ra_idx]  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (state >= ST_T0) && (state <= ST_T5);
    assign illegal = (state == ST_HALT);

endmodule

// File: doc/alu_control_sequencer.md
# alu_control_sequencer

Hardwired control unit for the Phase-1 datapath. It steps through the six-cycle fetch/execute sequence (T0–T5) for three-register ALU instructions. It sits directly upstream of `datapath`: its outputs drive the datapath's register-enable, bus-select and ALU-operation controls, replacing the per-instruction control processes in today's testbenches. It decodes the instruction from the datapath's `IR` output.

## Interface
Parameters:
- `NREGS`, 16: number of general registers; sets the width of `Rin` and `Rout`.
- `CNT_W`, 16: width of the instruction counter.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `clear`  in  1  one clock; reset is synchronous and active-high.
- `run`  in  1  level; while high, the unit keeps fetching instructions.
- `IR`  in  32  instruction from the datapath IR: opcode `[31:27]`, Ra `[26:23]`, Rb `[22:19]`, Rc `[18:15]`.
- `PCout`, `MARin`, `IncPC`, `PCin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Zin`, `Zlowout`  out  1 each  datapath strobes.
- `ADD`, `SUB`, `AND`, `OR`, `SHR`, `SHRA`, `SHL`, `ROR`, `ROL`  out  1 each  ALU operation select; at most one is high.
- `Rin`  out  NREGS  one-hot register write enable; bit n maps to `Rn`in.
- `Rout`  out  NREGS  one-hot register bus drive; bit n maps to `Rn`out.
- `busy`  out  1  high in T0–T5.
- `illegal`  out  1  high in HALT.
- `instr_count`  out  CNT_W  number of completed instructions.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT.
- All strobe outputs are Moore outputs decoded from the registered state and `IR`. No output is registered separately.
- Per-state outputs (every unlisted output is 0):
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - T3: `Rout[Rb]`, Yin.
  - T4: `Rout[Rc]`, Zin, plus the decoded ALU select.
  - T5: Zlowout, `Rin[Ra]`.
- Opcodes:
  - ADD 00000, SUB 00001, AND 00010, OR 00011.
  - SHR 00100, SHRA 00101, SHL 00110, ROR 00111, ROL 01000.
  - Any other opcode is illegal.
- Transitions:
  - IDLE → T0 when `run` = 1.
  - T0 → T1 → T2 → T3, unconditionally.
  - T3 → T4 if the opcode is legal; T3 → HALT otherwise.
  - T4 → T5.
  - T5 → T0 if `run` = 1; T5 → IDLE otherwise.
  - HALT is held until `clear`.
- `instr_count` increments on the T5 → (T0 | IDLE) edge and wraps modulo 2^CNT_W.
- Ra == Rb or Ra == Rc is legal; no special handling.
- R0 is an ordinary register here.
- Deasserting `run` mid-instruction does not abort it. The unit completes T5, then goes to IDLE.

## Timing
- Reset: when `clear` is high at a rising edge, the next state is IDLE and `instr_count` becomes 0. This overrides `run` and any state, including mid-instruction and HALT.
- While in IDLE or after reset, every strobe output, `Rin`, `Rout`, `busy` and `illegal` are 0.
- Start latency: `run` sampled high in IDLE gives T0 outputs in the next cycle.
- Each instruction takes exactly 6 cycles. Back-to-back instructions have no gap (T5 → T0).
- The memory read completes within T1: `Mdatain` is valid while Read is high. IR is valid from T3 onward, so decode uses `IR` only in T3–T5.
- `IR` changes outside T3–T5 have no effect on outputs.

## Structure
- Shared package `cpu_pkg`:
  - 5-bit opcode localparams.
  - State enumeration.
  - IR field bit positions.
- One sub-module, `alu_op_decode`: combinational decoder from opcode to the one-hot ALU select plus a `legal` flag. It is reused later by the full control unit.

## Test plan
- **Reset:** hold `clear` for 2 cycles with `run` = 1 → IDLE, all outputs 0, `instr_count` = 0.
- **ROR R7, R0, R4:** IR = 0x3B820000, datapath R0 = 0xABCD1234, R4 = 8.
  - T3: `Rout` = 0x0001.
  - T4: `Rout` = 0x0010, ROR = 1.
  - T5: `Rin` = 0x0080.
  - Result: R7 = 0x34ABCD12, `instr_count` = 1.
- **ADD R3, R1, R2:** IR = 0x01890000, R1 = 5, R2 = 7 → R3 = 12. Only ADD is high in T4.
- **Back-to-back:** `run` held high for 12 cycles → two instructions, T5 followed directly by T0, `instr_count` = 2. Then `run` = 0 → IDLE after T5.
- **Illegal opcode:** IR = 0xF8000000 → HALT after T3, `illegal` = 1, no `Rin` bit asserted. `clear` returns the unit to IDLE.
- **Reset mid-instruction:** `clear` asserted in T4 → IDLE next cycle, no `Rin` asserted, `instr_count` unchanged at 0.
